hpdmc_idelay_ctl: RTL and testbench



---
 rtl/hpdmc_idelay_ctl.sv | 171 +++++++++++++++++
 tb/tb_hpdmc_idelay_ctl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_idelay_ctl.sv
// Sequencer for the shared CAL/RST/CE/INC controls of the DQ input-delay bank.
// Issues spaced single-cycle pulses for calibrate, reset and N-step
// increment/decrement commands, and tracks the current tap value, stopping
// at the tap range limits instead of wrapping.
module hpdmc_idelay_ctl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_TAP       = 255
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_count,
    output logic       cmd_done,
    output logic       sat,
    output logic [7:0] tap,
    output logic       idelay_cal,
    output logic       idelay_rst,
    output logic       idelay_ce,
    output logic       idelay_inc
);

    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TAP_MAX = 8'(MAX_TAP);

    typedef enum logic [2:0] {
        IDLE, CAL_P, CAL_W, RST_P, RST_W, STEP_P, STEP_W
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wcnt;
    logic [7:0]        remaining;
    logic              dir_up;

    logic [7:0]        step_rem;
    logic              step_up;
    logic              step_go;
    logic              step_sat;

    // True when the tap cannot move any further in the requested direction.
    function automatic logic at_limit(input logic [7:0] t, input logic up);
        return up ? (t == TAP_MAX) : (t == 8'd0);
    endfunction

    // Saturating one-tap move; never wraps past 0 or TAP_MAX.
    function automatic logic [7:0] tap_step(input logic [7:0] t, input logic up);
        if (up && t != TAP_MAX)
            return t + 8'd1;
        else if (!up && t != 8'd0)
            return t - 8'd1;
        else
            return t;
    endfunction

    assign cmd_ready = (state == IDLE);

    // Pre-step decision: uses the fresh command at acceptance, the latched
    // remaining count and direction at the end of each settle window.
    always_comb begin
        step_rem = remaining;
        step_up  = dir_up;
        if (state == IDLE) begin
            step_rem = cmd_count;
            step_up  = ~cmd_op[0];
        end
        step_go  = (step_rem != 8'd0) && !at_limit(tap, step_up);
        step_sat = (step_rem != 8'd0) &&  at_limit(tap, step_up);
    end

    // Command sequencer with registered pulse outputs and tap tracking.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            remaining  <= 8'd0;
            dir_up     <= 1'b0;
            tap        <= 8'd0;
            sat        <= 1'b0;
            cmd_done   <= 1'b0;
            idelay_cal <= 1'b0;
            idelay_rst <= 1'b0;
            idelay_ce  <= 1'b0;
            idelay_inc <= 1'b0;
        end else begin
            cmd_done   <= 1'b0;
            idelay_cal <= 1'b0;
            idelay_rst <= 1'b0;
            idelay_ce  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sat <= 1'b0;
                        case (cmd_op)
                            2'b00: begin
                                state      <= CAL_P;
                                idelay_cal <= 1'b1;
                            end
                            2'b01: begin
                                state      <= RST_P;
                                idelay_rst <= 1'b1;
                                tap        <= 8'd0;
                            end
                            default: begin
                                dir_up     <= step_up;
                                idelay_inc <= step_up;
                                if (step_go) begin
                                    state     <= STEP_P;
                                    idelay_ce <= 1'b1;
                                    tap       <= tap_step(tap, step_up);
                                    remaining <= step_rem - 8'd1;
                                end else begin
                                    cmd_done <= 1'b1;
                                    sat      <= step_sat;
                                end
                            end
                        endcase
                    end
                end
                CAL_P: begin
                    state <= CAL_W;
                    wcnt  <= WAIT_LOAD;
                end
                CAL_W: begin
                    if (wcnt == '0) begin
                        state      <= RST_P;
                        idelay_rst <= 1'b1;
                        tap        <= 8'd0;
                    end else begin
                        wcnt <= wcnt - WAIT_W'(1);
                    end
                end
                RST_P: begin
                    state <= RST_W;
                    wcnt  <= WAIT_LOAD;
                end
                RST_W: begin
                    if (wcnt == '0) begin
                        state    <= IDLE;
                        cmd_done <= 1'b1;
                    end else begin
                        wcnt <= wcnt - WAIT_W'(1);
                    end
                end
                STEP_P: begin
                    state <= STEP_W;
                    wcnt  <= WAIT_LOAD;
                end
                STEP_W: begin
                    if (wcnt == '0) begin
                        if (step_go) begin
                            state     <= STEP_P;
                            idelay_ce <= 1'b1;
                            tap       <= tap_step(tap, step_up);
                            remaining <= step_rem - 8'd1;
                        end else begin
                            state    <= IDLE;
                            cmd_done <= 1'b1;
                            sat      <= step_sat;
                        end
                    end else begin
                        wcnt <= wcnt - WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpdmc_idelay_ctl.sv
// Scoreboard bench for hpdmc_idelay_ctl: expectations are pushed at command
// acceptance and a monitor checks every pulse and completion against them.
module tb_hpdmc_idelay_ctl;

    localparam int S    = 8;
    localparam int MAXT = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_count = 8'd0;
    logic       cmd_ready, cmd_done, sat;
    logic [7:0] tap;
    logic       idelay_cal, idelay_rst, idelay_ce, idelay_inc;

    hpdmc_idelay_ctl #(.SETTLE_CYCLES(S), .MAX_TAP(MAXT)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count),
        .cmd_done(cmd_done), .sat(sat), .tap(tap),
        .idelay_cal(idelay_cal), .idelay_rst(idelay_rst),
        .idelay_ce(idelay_ce), .idelay_inc(idelay_inc)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; an output seen at a falling edge was set
    // by edge number cyc.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;      // acceptance edge
        int lat;    // cmd_done visible lat cycles after acceptance
        int op;
        int tap;
        int sat;
        int n_ce;
        int up;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ce_seen = 0, cal_seen = 0, rst_seen = 0;
    bit   abort = 1'b0;
    int   model_tap = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && !abort) begin
                exp_t h;
                int   rel;
                rel = 0;
                if (q.size() > 0) begin
                    h   = q[0];
                    rel = cyc - h.t;
                    if (rel >= 0 && rel <= h.lat - 2)
                        chk("ready_busy", int'(cmd_ready), 0);
                end
                if (idelay_ce) begin
                    if (q.size() == 0) chk("ce_spurious", 1, 0);
                    else begin
                        chk("ce_op_is_step", int'(h.op >= 2), 1);
                        chk("ce_phase", rel % (S + 1), 0);
                        chk("ce_inc_level", int'(idelay_inc), h.up);
                        ce_seen++;
                    end
                end
                if (idelay_cal) begin
                    if (q.size() == 0) chk("cal_spurious", 1, 0);
                    else begin
                        chk("cal_op", h.op, 0);
                        chk("cal_time", rel, 0);
                        cal_seen++;
                    end
                end
                if (idelay_rst) begin
                    if (q.size() == 0) chk("rst_spurious", 1, 0);
                    else begin
                        chk("rst_op", int'(h.op <= 1), 1);
                        chk("rst_time", rel, (h.op == 0) ? 1 + S : 0);
                        rst_seen++;
                    end
                end
                if (cmd_done) begin
                    if (q.size() == 0) chk("done_spurious", 1, 0);
                    else begin
                        h = q.pop_front();
                        chk("done_time", rel, h.lat - 1);
                        chk("done_tap", int'(tap), h.tap);
                        chk("done_sat", int'(sat), h.sat);
                        chk("ce_count", ce_seen, h.n_ce);
                        chk("cal_count", cal_seen, int'(h.op == 0));
                        chk("rst_count", rst_seen, int'(h.op <= 1));
                        if (h.op >= 2) chk("done_inc_level", int'(idelay_inc), h.up);
                        ce_seen = 0; cal_seen = 0; rst_seen = 0;
                    end
                end
            end
        end
    endtask

    // Reference model: a command's outcome from the tap range rules.
    task automatic issue(input int op, input int cnt, output int t_acc);
        int   n;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_count = 8'(cnt);
        n = 0;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        t_acc = -1;
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            t_acc = cyc + 1;
            e.t = t_acc; e.op = op; e.up = 0; e.n_ce = 0; e.sat = 0;
            if (op == 0) begin
                e.lat = 3 + 2 * S; model_tap = 0;
            end else if (op == 1) begin
                e.lat = 2 + S; model_tap = 0;
            end else begin
                int avail;
                e.up  = (op == 2) ? 1 : 0;
                avail = e.up ? (MAXT - model_tap) : model_tap;
                e.n_ce = (cnt < avail) ? cnt : avail;
                e.sat  = (cnt > avail) ? 1 : 0;
                e.lat  = 1 + e.n_ce * (S + 1);
                model_tap = e.up ? model_tap + e.n_ce : model_tap - e.n_ce;
            end
            e.tap = model_tap;
            q.push_back(e);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        int t1, t2, ta;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_outputs", int'({idelay_cal, idelay_rst, idelay_ce, idelay_inc, cmd_done, sat}), 0);
        chk("reset_tap", int'(tap), 0);
        rst = 1'b0;

        issue(0, 0, ta);  drain();          // calibrate
        issue(2, 3, ta);  drain();          // 3 steps up from 0
        issue(2, 250, ta); drain();         // to 253
        issue(2, 5, ta);  drain();          // saturates at MAX_TAP after 2
        issue(3, 253, ta); drain();         // down to 2
        issue(3, 4, ta);  drain();          // saturates at 0 after 2
        issue(3, 0, ta);  drain();          // zero-pulse completion

        // Second request held while the first is busy.
        issue(2, 2, t1);
        issue(2, 2, t2);
        chk("held_accept_edge", t2, t1 + 1 + 2 * (S + 1));
        drain();

        for (int i = 0; i < 40; i++) begin
            int op, cnt;
            op  = $urandom_range(0, 3);
            cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 12);
            issue(op, cnt, ta);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // Abort an INC by 10 part-way through.
        issue(0, 0, ta); drain();
        issue(2, 10, ta);
        while (cyc < ta + 3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", int'({idelay_cal, idelay_rst, idelay_ce, idelay_inc, cmd_done, sat}), 0);
        chk("abort_tap", int'(tap), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        q.delete();
        ce_seen = 0; cal_seen = 0; rst_seen = 0;
        model_tap = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(cmd_done), 0);
        end
        abort = 1'b0;

        issue(0, 0, ta); drain();
        issue(2, 1, ta); drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
